// File: rtl/buzzer_arbiter_if.sv
// CPU-facing result/acknowledge bundle of the buzzer arbiter.
interface buzzer_arbiter_if;
    logic       clear;
    logic       playerInputFlag;
    logic [1:0] firstPlayerFlag;
    logic [7:0] switchInput;

    modport master (
        output clear,
        input  playerInputFlag,
        input  firstPlayerFlag,
        input  switchInput
    );

    modport slave (
        input  clear,
        output playerInputFlag,
        output firstPlayerFlag,
        output switchInput
    );
endinterface

// File: rtl/buzzer_arbiter.sv
// Player input front end: synchronizes/debounces four buzzers, picks the first
// press, latches that player's answer switches until the CPU acknowledges.
module buzzer_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [35:0]       gpins,
    input  logic              board_switch,
    buzzer_arbiter_if.slave   cpu,
    output logic [1:0]        state_dbg
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ARMED        = 2'd1,
        LATCHED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t           state, nxt;
    logic [36:0]      sync1, sync2;
    logic [31:0]      sw_s;
    logic [3:0]       btn_s;
    logic             bs_s;
    logic [3:0]       db, db_d, ev;
    logic [CNT_W-1:0] cnt [4];
    logic [1:0]       win_idx;
    logic [7:0]       win_sw;
    logic             pif_q, pif_n;
    logic [1:0]       fpf_q, fpf_n;
    logic [7:0]       sw_q, sw_n;

    // board_switch shares the synchronizer so the FSM never sees a raw async level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {board_switch, gpins};
            sync2 <= sync1;
        end
    end

    assign sw_s  = sync2[31:0];
    assign btn_s = sync2[35:32];
    assign bs_s  = sync2[36];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db   <= '0;
            db_d <= '0;
            for (int unsigned p = 0; p < 4; p++) cnt[p] <= '0;
        end else begin
            db_d <= db;
            for (int unsigned p = 0; p < 4; p++) begin
                if (btn_s[p] == db[p]) begin
                    cnt[p] <= '0;
                end else if (cnt[p] == CNT_MAX) begin
                    db[p]  <= ~db[p];
                    cnt[p] <= '0;
                end else begin
                    cnt[p] <= cnt[p] + 1'b1;
                end
            end
        end
    end

    assign ev = db & ~db_d;

    // Lowest index wins a same-cycle tie
    always_comb begin
        if (ev[0])      win_idx = 2'd0;
        else if (ev[1]) win_idx = 2'd1;
        else if (ev[2]) win_idx = 2'd2;
        else            win_idx = 2'd3;
    end

    always_comb begin
        case (win_idx)
            2'd0:    win_sw = sw_s[7:0];
            2'd1:    win_sw = sw_s[15:8];
            2'd2:    win_sw = sw_s[23:16];
            default: win_sw = sw_s[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pif_q <= 1'b0;
            fpf_q <= '0;
            sw_q  <= '0;
        end else begin
            state <= nxt;
            pif_q <= pif_n;
            fpf_q <= fpf_n;
            sw_q  <= sw_n;
        end
    end

    always_comb begin
        nxt = state;
        if (!bs_s) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:         nxt = WAIT_RELEASE;
                WAIT_RELEASE: if (db == '0) nxt = ARMED;
                ARMED:        if (|ev) nxt = LATCHED;
                LATCHED:      if (cpu.clear) nxt = WAIT_RELEASE;
                default:      nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pif_n = pif_q;
        fpf_n = fpf_q;
        sw_n  = sw_q;
        if (!bs_s || state == IDLE) begin
            pif_n = 1'b0;
            fpf_n = '0;
            sw_n  = '0;
        end else if (state == ARMED && |ev) begin
            pif_n = 1'b1;
            fpf_n = win_idx;
            sw_n  = win_sw;
        end else if (state == LATCHED && cpu.clear) begin
            pif_n = 1'b0;
        end
    end

    assign cpu.playerInputFlag = pif_q;
    assign cpu.firstPlayerFlag = fpf_q;
    assign cpu.switchInput     = sw_q;
    assign state_dbg           = state;
endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with DEBOUNCE_CYCLES=4.
module tb_buzzer_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] gpins;
    logic        board_switch;
    logic [1:0]  state_dbg;
    int          tests = 0;
    int          fails = 0;

    buzzer_arbiter_if bus ();

    buzzer_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .gpins        (gpins),
        .board_switch (board_switch),
        .cpu          (bus),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [35:0] gp;
        logic        bs;
        logic        clr;
        int unsigned cyc;
        logic        pif;
        logic [1:0]  fpf;
        logic [7:0]  sw;
        logic [1:0]  st;
    } vec_t;

    vec_t vt[$];

    function automatic logic [35:0] pins(input logic [3:0] btn, input logic [7:0] s0,
                                         input logic [7:0] s1, input logic [7:0] s2,
                                         input logic [7:0] s3);
        return {btn, s3, s2, s1, s0};
    endfunction

    task automatic add(input string name, input logic [35:0] gp, input logic bs, input logic clr,
                       input int unsigned cyc, input logic pif, input logic [1:0] fpf,
                       input logic [7:0] sw, input logic [1:0] st);
        vec_t v;
        v.name = name; v.gp = gp; v.bs = bs; v.clr = clr; v.cyc = cyc;
        v.pif = pif; v.fpf = fpf; v.sw = sw; v.st = st;
        vt.push_back(v);
    endtask

    task automatic run(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic pif, input logic [1:0] fpf,
                         input logic [7:0] sw, input logic [1:0] st);
        tests++;
        if ({bus.playerInputFlag, bus.firstPlayerFlag, bus.switchInput, state_dbg} !== {pif, fpf, sw, st}) begin
            fails++;
            $display("FAIL %s: got flag=%0b player=%0d sw=%02h state=%0d, want flag=%0b player=%0d sw=%02h state=%0d",
                     name, bus.playerInputFlag, bus.firstPlayerFlag, bus.switchInput, state_dbg,
                     pif, fpf, sw, st);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; gpins = '0; board_switch = 1'b0; bus.clear = 1'b0;
        #2;
        check("reset_state", 1'b0, 2'd0, 8'h00, 2'd0);
        run(2);
        rst = 1'b1;

        // Reach LATCHED, then assert reset between clock edges
        board_switch = 1'b1;
        run(4);
        check("arm_before_rst", 1'b0, 2'd0, 8'h00, 2'd1);
        gpins = pins(4'b0001, 8'h96, 8'h00, 8'h00, 8'h00);
        run(7);
        check("win_before_rst", 1'b1, 2'd0, 8'h96, 2'd2);
        #3 rst = 1'b0;
        #1 check("rst_async", 1'b0, 2'd0, 8'h00, 2'd0);
        #1 rst = 1'b1;
        gpins = pins(4'b0100, 8'h00, 8'h00, 8'hC3, 8'h00);
        run(6);
        check("post_rst_pending", 1'b0, 2'd0, 8'h00, 2'd1);
        run(1);
        check("post_rst_win_p2", 1'b1, 2'd2, 8'hC3, 2'd2);

        rst = 1'b0; gpins = '0; board_switch = 1'b0; bus.clear = 1'b0;
        run(2);
        rst = 1'b1;

        // enable latency
        add("en_idle",      pins(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00), 1, 0, 2,  0, 0, 8'h00, 0);
        add("en_wait",      pins(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00), 1, 0, 1,  0, 0, 8'h00, 3);
        add("en_armed",     pins(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00), 1, 0, 1,  0, 0, 8'h00, 1);
        // single press, flag exactly after edge 6
        add("p1_edge5",     pins(4'b0010, 8'h00, 8'hA5, 8'h00, 8'h00), 1, 0, 6,  0, 0, 8'h00, 1);
        add("p1_edge6",     pins(4'b0010, 8'h00, 8'hA5, 8'h00, 8'h00), 1, 0, 1,  1, 1, 8'hA5, 2);
        // clear with buzzer still held, then release
        add("clr_held",     pins(4'b0010, 8'h00, 8'hA5, 8'h00, 8'h00), 1, 1, 1,  0, 1, 8'hA5, 3);
        add("held_wait",    pins(4'b0010, 8'h00, 8'hA5, 8'h00, 8'h00), 1, 0, 10, 0, 1, 8'hA5, 3);
        add("rel_wait",     pins(4'b0000, 8'h00, 8'hA5, 8'h00, 8'h00), 1, 0, 6,  0, 1, 8'hA5, 3);
        add("rel_armed",    pins(4'b0000, 8'h00, 8'hA5, 8'h00, 8'h00), 1, 0, 1,  0, 1, 8'hA5, 1);
        // glitch rejection: 3-cycle pulse, then 4-cycle pulse
        add("glitch_hi",    pins(4'b1000, 8'h00, 8'hA5, 8'h00, 8'h3C), 1, 0, 3,  0, 1, 8'hA5, 1);
        add("glitch_none",  pins(4'b0000, 8'h00, 8'hA5, 8'h00, 8'h3C), 1, 0, 10, 0, 1, 8'hA5, 1);
        add("pulse4_hi",    pins(4'b1000, 8'h00, 8'hA5, 8'h00, 8'h3C), 1, 0, 4,  0, 1, 8'hA5, 1);
        add("pulse4_e5",    pins(4'b0000, 8'h00, 8'hA5, 8'h00, 8'h3C), 1, 0, 2,  0, 1, 8'hA5, 1);
        add("pulse4_win",   pins(4'b0000, 8'h00, 8'hA5, 8'h00, 8'h3C), 1, 0, 1,  1, 3, 8'h3C, 2);
        add("clr_p3",       pins(4'b0000, 8'h00, 8'hA5, 8'h00, 8'h3C), 1, 1, 1,  0, 3, 8'h3C, 3);
        add("p3_db_fall",   pins(4'b0000, 8'h00, 8'hA5, 8'h00, 8'h3C), 1, 0, 2,  0, 3, 8'h3C, 3);
        add("p3_rearm",     pins(4'b0000, 8'h00, 8'hA5, 8'h00, 8'h3C), 1, 0, 1,  0, 3, 8'h3C, 1);
        // tie 0/2, then lockout of player 3
        add("tie_p0",       pins(4'b0101, 8'h11, 8'hA5, 8'h22, 8'h3C), 1, 0, 7,  1, 0, 8'h11, 2);
        add("lockout_p3",   pins(4'b1101, 8'h11, 8'hA5, 8'h22, 8'h3C), 1, 0, 8,  1, 0, 8'h11, 2);
        add("clr_p0_held",  pins(4'b0001, 8'h11, 8'hA5, 8'h22, 8'h3C), 1, 1, 1,  0, 0, 8'h11, 3);
        add("p0_held_wait", pins(4'b0001, 8'h11, 8'hA5, 8'h22, 8'h3C), 1, 0, 12, 0, 0, 8'h11, 3);
        add("p0_rel_wait",  pins(4'b0000, 8'h11, 8'hA5, 8'h22, 8'h3C), 1, 0, 6,  0, 0, 8'h11, 3);
        add("p0_rel_armed", pins(4'b0000, 8'h11, 8'hA5, 8'h22, 8'h3C), 1, 0, 1,  0, 0, 8'h11, 1);
        add("p2_new_sw",    pins(4'b0100, 8'h11, 8'hA5, 8'h5A, 8'h3C), 1, 0, 7,  1, 2, 8'h5A, 2);
        // disable beats clear
        add("dis_sync",     pins(4'b0100, 8'h11, 8'hA5, 8'h5A, 8'h3C), 0, 0, 2,  1, 2, 8'h5A, 2);
        add("dis_vs_clr",   pins(4'b0100, 8'h11, 8'hA5, 8'h5A, 8'h3C), 0, 1, 1,  0, 0, 8'h00, 0);
        // disable beats a same-cycle press event
        add("reen_armed",   pins(4'b0000, 8'h00, 8'h77, 8'h00, 8'h00), 1, 0, 8,  0, 0, 8'h00, 1);
        add("press_early",  pins(4'b0010, 8'h00, 8'h77, 8'h00, 8'h00), 1, 0, 4,  0, 0, 8'h00, 1);
        add("press_bs_low", pins(4'b0010, 8'h00, 8'h77, 8'h00, 8'h00), 0, 0, 2,  0, 0, 8'h00, 1);
        add("dis_vs_ev",    pins(4'b0010, 8'h00, 8'h77, 8'h00, 8'h00), 0, 0, 1,  0, 0, 8'h00, 0);
        add("dis_stays",    pins(4'b0010, 8'h00, 8'h77, 8'h00, 8'h00), 0, 0, 4,  0, 0, 8'h00, 0);

        foreach (vt[i]) begin
            gpins        = vt[i].gp;
            board_switch = vt[i].bs;
            bus.clear    = vt[i].clr;
            run(vt[i].cyc);
            check(vt[i].name, vt[i].pif, vt[i].fpf, vt[i].sw, vt[i].st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/buzzer_arbiter.md
# buzzer_arbiter

Front-end input stage for the player controllers. It synchronizes and debounces the four player buzzer buttons, decides which player pressed first, and captures that player's 8 answer switches. It holds the result until the CPU acknowledges it. Its outputs drive the memory-mapped I/O inputs of the exmem block (`playerInputFlag`, `firstPlayerFlag`, `switchInput`).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a synchronized buzzer level is accepted (>= 2).

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `gpins` in 36: `gpins[8p+7:8p]` are the answer switches of player p (p = 0..3); `gpins[32+p]` is the buzzer of player p, active-high.
- `board_switch` in 1: game enable; arbiter is armed only while high.
- `clear` in 1: single-cycle acknowledge from the CPU that re-arms the arbiter.
- `playerInputFlag` out 1: high while a captured press is pending.
- `firstPlayerFlag` out 2: index of the winning player.
- `switchInput` out 8: that player's switches, captured at the win.
- `state_dbg` out 2: current FSM state encoding (IDLE=0, ARMED=1, LATCHED=2, WAIT_RELEASE=3).

## Operation
- Synchronization:
  - Every `gpins` bit passes through a 2-flop synchronizer.
  - Switches are not debounced.
- Debounce, per buzzer p:
  - Each buzzer has a debounced level `db[p]` and a counter of width clog2(`DEBOUNCE_CYCLES`).
  - While the synchronized level equals `db[p]`, the counter is 0.
  - Otherwise the counter increments each cycle. When it reaches `DEBOUNCE_CYCLES`-1 and the levels still differ, `db[p]` flips on the next edge and the counter returns to 0.
  - Any return to equality before then zeroes the counter.
  - A press event `ev[p]` is a 0->1 transition of `db[p]`, one cycle wide.
- FSM:
  - IDLE: outputs cleared. Go to WAIT_RELEASE when `board_switch`=1.
  - WAIT_RELEASE: go to ARMED once all `db` are 0. This stops a held buzzer from winning.
  - ARMED: on any `ev`, select the lowest p with `ev[p]`=1 (player 0 has highest priority for same-cycle ties). Register `firstPlayerFlag`=p and `switchInput`=synchronized switches of p in that cycle, set `playerInputFlag`=1, then go to LATCHED.
  - LATCHED: outputs hold; further presses are ignored. On `clear`=1, drop `playerInputFlag` and go to WAIT_RELEASE. `firstPlayerFlag` and `switchInput` keep their values until the next win.
  - From any state, `board_switch`=0 forces IDLE on the next edge: all three outputs go to 0. This has priority over `clear` and `ev`.
- `clear` outside LATCHED is ignored.
- Reset (`rst`=0) acts immediately, regardless of `clk`:
  - State goes to IDLE.
  - `playerInputFlag`=0, `firstPlayerFlag`=0, `switchInput`=0, `state_dbg`=0.
  - All synchronizer flops, `db`, and counters go to 0.
  - Reset mid-LATCHED discards the pending result.

## Timing
- Raw buzzer first sampled high at edge 0 and held: `db[p]` rises after edge 1+`DEBOUNCE_CYCLES`.
- `playerInputFlag` is high after edge `DEBOUNCE_CYCLES`+2, i.e. in the next cycle.
- Release follows the same latency to `db[p]`=0.
- `clear` sampled in LATCHED: `playerInputFlag` is low after that same edge.
- Re-arm after `clear` with all buzzers already released: ARMED after 2 edges (LATCHED->WAIT_RELEASE->ARMED).
- `board_switch` passes through the synchronizer, so IDLE entry/exit takes 2 edges plus 1 edge of latency.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset:** `rst`=0 mid-LATCHED with flag=1 -> all outputs 0 immediately. After release, a press by player 2 wins normally.
- **Single press:** `board_switch`=1, player 1 switches=8'hA5, buzzer 1 raised at edge 0 and held -> `playerInputFlag`=1 after edge 6, `firstPlayerFlag`=1, `switchInput`=8'hA5.
- **Glitch rejection:** buzzer 3 high for 3 cycles then low -> no flag ever. A 4-cycle-stable pulse that reaches `db` -> flag with `firstPlayerFlag`=3.
- **Tie and lockout:** buzzers 2 and 0 rise in the same cycle -> `firstPlayerFlag`=0. A later press by player 3 while LATCHED -> outputs unchanged.
- **Clear and re-arm:** `clear` pulse in LATCHED -> flag 0 next edge. Buzzer 0 still held -> stays in WAIT_RELEASE (`state_dbg`=3) with no new flag. After release, ARMED; player 2 press wins with the new switch value.
- **Disable priority:** `board_switch` dropped in the same cycle as `clear` and a new press -> IDLE, all outputs 0, no win registered.
